// File: rtl/bsram_sd_backup.sv
// Save-RAM backup: moves BSRAM (in SDRAM) to/from the mounted SD image one 512-byte sector at a time.
// Optional BSRAM_DIRTY_EN: adds bk_core_we and skips saves when the core has not written BSRAM.
module bsram_sd_backup #(
    parameter int BK_AW = 20
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [23:0]      ram_mask,
    input  logic             img_mounted,
    input  logic [31:0]      img_size,
    input  logic             save_req,
    output logic [31:0]      sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    input  logic [8:0]       sd_buff_addr,
    input  logic [7:0]       sd_buff_dout,
    output logic [7:0]       sd_buff_din,
    input  logic             sd_buff_wr,
`ifdef BSRAM_DIRTY_EN
    input  logic             bk_core_we,
`endif
    output logic [BK_AW-1:0] bk_addr,
    output logic [7:0]       bk_din,
    input  logic [7:0]       bk_dout,
    output logic             bk_we,
    output logic             bk_req,
    input  logic             bk_ack,
    output logic             busy
);
    typedef enum logic [2:0] {
        IDLE, LD_RD, LD_WAIT, LD_COPY, SV_COPY, SV_WR, SV_WAIT, NEXT
    } state_t;

    state_t r_state, w_next;

    logic [7:0]       r_buf [0:511];
    logic [7:0]       r_rd_data, r_sd_din;
    logic [10:0]      r_sector;
    logic [8:0]       r_byte;
    logic             r_save, r_mounted, r_issued, r_fetched;
    logic             r_mnt_d, r_save_d, r_ack_d;
    logic             r_bk_req, r_bk_we;
    logic [BK_AW-1:0] r_bk_addr;
    logic [7:0]       r_bk_din;

    logic w_mnt_rise, w_save_rise, w_ack_fall, w_bk_done;
    logic w_last_byte, w_last_sec, w_has_ram, w_save_ok;
    logic w_start_ld, w_start_sv, w_done;

    assign w_mnt_rise  = img_mounted & ~r_mnt_d;
    assign w_save_rise = save_req & ~r_save_d;
    assign w_ack_fall  = r_ack_d & ~sd_ack;
    assign w_bk_done   = r_issued & (bk_ack == r_bk_req);
    assign w_last_byte = (r_byte == 9'd511);
    assign w_last_sec  = (r_sector == ram_mask[19:9]);
    assign w_has_ram   = (ram_mask != 24'd0);
    // A mount edge masks a simultaneous save edge even when no load follows.
    assign w_start_ld  = w_mnt_rise & (img_size != 32'd0) & w_has_ram;
    assign w_start_sv  = ~w_mnt_rise & w_save_rise & r_mounted & w_has_ram & w_save_ok;
    assign w_done      = (r_state == NEXT) & w_last_sec;

`ifdef BSRAM_DIRTY_EN
    logic r_dirty;
    always_ff @(posedge clk_sys) begin
        if (reset)           r_dirty <= 1'b0;
        else if (bk_core_we) r_dirty <= 1'b1;
        else if (w_done)     r_dirty <= 1'b0;
    end
    assign w_save_ok = r_dirty;
`else
    assign w_save_ok = 1'b1;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ld) w_next = LD_RD;
                     else if (w_start_sv) w_next = SV_COPY;
            LD_RD:   if (sd_ack) w_next = LD_WAIT;
            LD_WAIT: if (w_ack_fall) w_next = LD_COPY;
            LD_COPY: if (w_bk_done && w_last_byte) w_next = NEXT;
            SV_COPY: if (w_bk_done && w_last_byte) w_next = SV_WR;
            SV_WR:   if (sd_ack) w_next = SV_WAIT;
            SV_WAIT: if (w_ack_fall) w_next = NEXT;
            NEXT:    if (w_last_sec) w_next = IDLE;
                     else w_next = r_save ? SV_COPY : LD_RD;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != IDLE);
        sd_rd = (r_state == LD_RD);
        sd_wr = (r_state == SV_WR);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sector  <= '0;
            r_byte    <= '0;
            r_save    <= 1'b0;
            r_mounted <= 1'b0;
            r_issued  <= 1'b0;
            r_fetched <= 1'b0;
            r_bk_req  <= bk_ack;
            r_bk_we   <= 1'b0;
            r_bk_addr <= '0;
            r_bk_din  <= '0;
            r_mnt_d   <= 1'b0;
            r_save_d  <= 1'b0;
            r_ack_d   <= 1'b0;
        end else begin
            r_mnt_d  <= img_mounted;
            r_save_d <= save_req;
            r_ack_d  <= sd_ack;
            case (r_state)
                IDLE: begin
                    if (w_mnt_rise) r_mounted <= 1'b1;
                    if (w_start_ld || w_start_sv) begin
                        r_sector  <= '0;
                        r_byte    <= '0;
                        r_issued  <= 1'b0;
                        r_fetched <= 1'b0;
                        r_save    <= w_start_sv;
                    end
                end
                LD_WAIT: if (w_ack_fall) begin
                    r_byte    <= '0;
                    r_fetched <= 1'b0;
                    r_issued  <= 1'b0;
                end
                // fetch from the buffer, then issue the write, then wait for the toggle ack
                LD_COPY: begin
                    if (!r_fetched) begin
                        r_fetched <= 1'b1;
                    end else if (!r_issued) begin
                        r_issued  <= 1'b1;
                        r_bk_req  <= ~r_bk_req;
                        r_bk_we   <= 1'b1;
                        r_bk_addr <= BK_AW'({r_sector, r_byte});
                        r_bk_din  <= r_rd_data;
                    end else if (w_bk_done) begin
                        r_byte    <= r_byte + 9'd1;
                        r_fetched <= 1'b0;
                        r_issued  <= 1'b0;
                    end
                end
                SV_COPY: begin
                    if (!r_issued) begin
                        r_issued  <= 1'b1;
                        r_bk_req  <= ~r_bk_req;
                        r_bk_we   <= 1'b0;
                        r_bk_addr <= BK_AW'({r_sector, r_byte});
                    end else if (w_bk_done) begin
                        r_byte   <= r_byte + 9'd1;
                        r_issued <= 1'b0;
                    end
                end
                NEXT: if (!w_last_sec) begin
                    r_sector  <= r_sector + 11'd1;
                    r_byte    <= '0;
                    r_issued  <= 1'b0;
                    r_fetched <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (sd_buff_wr)
            r_buf[sd_buff_addr] <= sd_buff_dout;
        else if (r_state == SV_COPY && w_bk_done)
            r_buf[r_byte] <= bk_dout;
        r_rd_data <= r_buf[r_byte];
        r_sd_din  <= r_buf[sd_buff_addr];
    end

    assign sd_lba      = {21'd0, r_sector};
    assign sd_buff_din = r_sd_din;
    assign bk_req      = r_bk_req;
    assign bk_we       = r_bk_we;
    assign bk_addr     = r_bk_addr;
    assign bk_din      = r_bk_din;
endmodule

// File: tb/tb_bsram_sd_backup.sv
// Bench for bsram_sd_backup: SD-card and SDRAM behavioural models plus directed steps with random data.
module tb_bsram_sd_backup;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset, img_mounted, save_req;
    logic [23:0] ram_mask;
    logic [31:0] img_size, sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic [19:0] bk_addr;
    logic [7:0]  bk_din, bk_dout;
    logic        bk_we, bk_req, bk_ack, busy;
`ifdef BSRAM_DIRTY_EN
    logic        bk_core_we;
`endif

    bsram_sd_backup #(.BK_AW(20)) dut (
        .clk_sys(clk_sys), .reset(reset), .ram_mask(ram_mask),
        .img_mounted(img_mounted), .img_size(img_size), .save_req(save_req),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
`ifdef BSRAM_DIRTY_EN
        .bk_core_we(bk_core_we),
`endif
        .bk_addr(bk_addr), .bk_din(bk_din), .bk_dout(bk_dout), .bk_we(bk_we),
        .bk_req(bk_req), .bk_ack(bk_ack), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    // Owned by the main sequence
    logic [7:0] img [0:4095];
    int         bk_dly_fix;

    // SD card model: serves reads from img, captures writes into sd_img
    logic [7:0] sd_img [0:4095];
    int         rd_lbas[$];
    int         wr_lbas[$];
    initial begin
        int lba;
        bit rd;
        sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            if (reset === 1'b0 && (sd_rd === 1'b1 || sd_wr === 1'b1)) begin
                rd  = (sd_rd === 1'b1);
                lba = int'(sd_lba);
                if (rd) rd_lbas.push_back(lba);
                else    wr_lbas.push_back(lba);
                repeat (2) @(posedge clk_sys);
                #1;
                if (reset === 1'b0) sd_ack = 1'b1;
                for (int i = 0; i < 512 && reset === 1'b0; i++) begin
                    sd_buff_addr = 9'(i);
                    if (rd) begin
                        sd_buff_dout = img[(lba * 512 + i) & 4095];
                        sd_buff_wr   = 1'b1;
                    end
                    @(posedge clk_sys); #1;
                    if (!rd) sd_img[(lba * 512 + i) & 4095] = sd_buff_din;
                end
                sd_buff_wr = 1'b0;
                sd_ack     = 1'b0;
            end
        end
    end

    // SDRAM BSRAM model: toggle handshake with configurable ack delay
    logic [7:0] mem [0:4095];
    int         wcnt [0:4095];
    int         n_tog = 0, n_wr = 0, n_rd = 0, n_oob = 0, n_viol = 0;
    initial begin
        logic        req_v, we_v, aborted;
        logic [19:0] a_v;
        logic [7:0]  d_v;
        int          dly;
        bk_ack = 1'b0; bk_dout = '0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]  = 8'($urandom);
            wcnt[i] = 0;
        end
        forever begin
            @(posedge clk_sys); #1;
            if (reset === 1'b0 && !$isunknown(bk_req) && bk_req !== bk_ack) begin
                req_v = bk_req; a_v = bk_addr; we_v = bk_we; d_v = bk_din;
                n_tog++;
                if (a_v > ram_mask[19:0]) n_oob++;
                dly = (bk_dly_fix >= 0) ? bk_dly_fix : int'($urandom_range(1, 0));
                aborted = 1'b0;
                for (int k = 0; k < dly && !aborted; k++) begin
                    @(posedge clk_sys); #1;
                    if (reset !== 1'b0) aborted = 1'b1;
                    else if (bk_req !== req_v) n_viol++;
                end
                if (!aborted) begin
                    if (we_v) begin
                        mem[a_v[11:0]] = d_v;
                        wcnt[a_v[11:0]]++;
                        n_wr++;
                    end else begin
                        bk_dout = mem[a_v[11:0]];
                        n_rd++;
                    end
                    bk_ack = req_v;
                end
            end
        end
    end

    int busy_cyc = 0;
    initial forever begin
        @(posedge clk_sys); #1;
        if (busy === 1'b1) busy_cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys); #2;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic pulse_mount(input logic [31:0] size);
        img_size = size; img_mounted = 1'b1;
        tick(2);
        img_mounted = 1'b0;
        tick(1);
    endtask

    int b0, w0, r0, t0, nw0, nr0, bad, n;
    logic [7:0] expv [0:2047];
    int         wsnap [0:2047];

    initial begin
        reset = 1'b1; ram_mask = 24'h7FF; img_mounted = 1'b0; img_size = '0;
        save_req = 1'b0; bk_dly_fix = -1;
`ifdef BSRAM_DIRTY_EN
        bk_core_we = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);
        tick(3);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_sd_rd",   64'(sd_rd),   64'd0);
        check("rst_sd_wr",   64'(sd_wr),   64'd0);
        check("rst_sd_lba",  64'(sd_lba),  64'd0);
        check("rst_bk_we",   64'(bk_we),   64'd0);
        check("rst_bk_addr", 64'(bk_addr), 64'd0);
        check("rst_bk_din",  64'(bk_din),  64'd0);
        check("rst_bk_req",  64'(bk_req),  64'(bk_ack));
        reset = 1'b0;
        tick(2);

        // save with nothing mounted
        b0 = busy_cyc; w0 = wr_lbas.size();
        save_req = 1'b1; tick(2); save_req = 1'b0; tick(30);
        check("nomount_busy", 64'(busy_cyc - b0), 64'd0);
        check("nomount_wr",   64'(wr_lbas.size() - w0), 64'd0);

        // full load, slow SDRAM ack, save edge during busy must be dropped
        bk_dly_fix = 7;
        r0 = rd_lbas.size(); t0 = n_tog; nw0 = n_wr;
        for (int i = 0; i < 2048; i++) wsnap[i] = wcnt[i];
        img_size = 32'd2048; img_mounted = 1'b1;
        tick(1);
        check("ld_busy_rise", 64'(busy), 64'd1);
        img_mounted = 1'b0;
        tick(100);
        save_req = 1'b1; tick(3); save_req = 1'b0;
        wait_idle("ld_done", 40000);
        tick(10);
        check("ld_nsec", 64'(rd_lbas.size() - r0), 64'd4);
        for (int k = 0; k < 4 && r0 + k < rd_lbas.size(); k++)
            check("ld_lba", 64'(rd_lbas[r0 + k]), 64'(k));
        check("ld_toggles", 64'(n_tog - t0), 64'd2048);
        check("ld_writes",  64'(n_wr - nw0), 64'd2048);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (wcnt[i] - wsnap[i] != 1) bad++;
        check("ld_once", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== img[i]) bad++;
        check("ld_data", 64'(bad), 64'd0);
        check("ld_viol", 64'(n_viol), 64'd0);
        check("ld_oob",  64'(n_oob), 64'd0);
        check("ld_save_dropped", 64'(wr_lbas.size() - w0), 64'd0);

        // mount an empty image, then save BSRAM to it
        bk_dly_fix = -1;
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
        b0 = busy_cyc; r0 = rd_lbas.size();
        pulse_mount(32'd0);
        tick(10);
        check("m0_noload", 64'(busy_cyc - b0), 64'd0);
        check("m0_nord",   64'(rd_lbas.size() - r0), 64'd0);
        for (int i = 0; i < 2048; i++) expv[i] = mem[i];
        w0 = wr_lbas.size(); nw0 = n_wr; nr0 = n_rd;
`ifdef BSRAM_DIRTY_EN
        bk_core_we = 1'b1; tick(1); bk_core_we = 1'b0; tick(1);
`endif
        save_req = 1'b1;
        tick(1);
        check("sv_busy_rise", 64'(busy), 64'd1);
        save_req = 1'b0;
        wait_idle("sv_done", 30000);
        check("sv_nsec", 64'(wr_lbas.size() - w0), 64'd4);
        for (int k = 0; k < 4 && w0 + k < wr_lbas.size(); k++)
            check("sv_lba", 64'(wr_lbas[w0 + k]), 64'(k));
        bad = 0;
        for (int i = 0; i < 2048; i++) if (sd_img[i] !== expv[i]) bad++;
        check("sv_data",   64'(bad), 64'd0);
        check("sv_nowr",   64'(n_wr - nw0), 64'd0);
        check("sv_reads",  64'(n_rd - nr0), 64'd2048);

        // no BSRAM: neither save nor mount may start anything
        ram_mask = 24'h0;
        b0 = busy_cyc; r0 = rd_lbas.size(); w0 = wr_lbas.size();
        save_req = 1'b1; tick(2); save_req = 1'b0; tick(20);
        pulse_mount(32'd2048);
        tick(20);
        check("nomask_busy", 64'(busy_cyc - b0), 64'd0);
        check("nomask_sd",   64'(rd_lbas.size() - r0 + wr_lbas.size() - w0), 64'd0);
        ram_mask = 24'h7FF;

        // reset in sector 2 of a load, then a fresh mount restarts from lba 0
        for (int i = 0; i < 4096; i++) img[i] = 8'($urandom);
        r0 = rd_lbas.size();
        pulse_mount(32'd2048);
        n = 0;
        while (rd_lbas.size() - r0 < 3 && n < 30000) begin
            tick(1);
            n++;
        end
        check("rstm_reach_s2", 64'(rd_lbas.size() - r0), 64'd3);
        tick(200);
        reset = 1'b1;
        tick(1);
        check("rstm_busy",   64'(busy),   64'd0);
        check("rstm_sd_rd",  64'(sd_rd),  64'd0);
        check("rstm_sd_lba", 64'(sd_lba), 64'd0);
        check("rstm_bk_req", 64'(bk_req), 64'(bk_ack));
        tick(2);
        reset = 1'b0;
        tick(3);
        check("rstm_idle", 64'(busy), 64'd0);
        r0 = rd_lbas.size();
        pulse_mount(32'd2048);
        wait_idle("rstm_reload_done", 30000);
        check("rstm_nsec", 64'(rd_lbas.size() - r0), 64'd4);
        if (rd_lbas.size() > r0) check("rstm_first_lba", 64'(rd_lbas[r0]), 64'd0);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== img[i]) bad++;
        check("rstm_data", 64'(bad), 64'd0);

        // single-sector BSRAM save (last_sector = 0)
        ram_mask = 24'h1FF;
        tick(2);
        for (int i = 0; i < 512; i++) expv[i] = mem[i];
        w0 = wr_lbas.size();
`ifdef BSRAM_DIRTY_EN
        save_req = 1'b1; tick(2); save_req = 1'b0; tick(20);
        check("dirty_ignored", 64'(wr_lbas.size() - w0), 64'd0);
        bk_core_we = 1'b1; tick(1); bk_core_we = 1'b0; tick(1);
`endif
        save_req = 1'b1;
        tick(1);
        check("one_busy_rise", 64'(busy), 64'd1);
        save_req = 1'b0;
        wait_idle("one_done", 10000);
        check("one_nsec", 64'(wr_lbas.size() - w0), 64'd1);
        if (wr_lbas.size() > w0) check("one_lba", 64'(wr_lbas[w0]), 64'd0);
        bad = 0;
        for (int i = 0; i < 512; i++) if (sd_img[i] !== expv[i]) bad++;
        check("one_data", 64'(bad), 64'd0);
        check("end_viol", 64'(n_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
